lcd_hd44780_ctrl: RTL and testbench
===================================

LCD_HD44780_CTRL -- requirements
Module: lcd_hd44780_ctrl

Interface
REQ-001 SHALL provide parameter T_PWRUP, default 750000: power-up wait in clk_clk cycles (15 ms at 50 MHz).
REQ-002 SHALL provide parameter T_SETUP, default 4: cycles RS/DATA are stable before E rises.
REQ-003 SHALL provide parameter T_EPW, default 12: cycles E is high.
REQ-004 SHALL provide parameter T_HOLD, default 4: cycles RS/DATA are held after E falls.
REQ-005 SHALL provide parameter T_CMD, default 2000: post-write wait for normal commands and data (40 us).
REQ-006 SHALL provide parameter T_CLR, default 82000: post-write wait for clear/home (1.64 ms).
REQ-007 clk_clk  in  1  single system clock; all logic on its rising edge.
REQ-008 reset_reset_n  in  1  reset, synchronous, active-low.
REQ-009 req_valid  in  1  requester has a byte to write.
REQ-010 req_ready  out  1  controller accepts a byte this cycle.
REQ-011 req_rs  in  1  0 = command, 1 = character data.
REQ-012 req_data  in  8  byte to write.
REQ-013 init_done  out  1  power-up init sequence complete.
REQ-014 lcd_rs  out  1  register select to panel.
REQ-015 lcd_rw  out  1  read/write; tied low (write-only controller).
REQ-016 lcd_e  out  1  enable strobe.
REQ-017 lcd_data  out  8  data bus; the top level drives the panel's inout bus from this.

Function
REQ-018 SHALL implement states PWRUP, INIT, IDLE, SETUP, EHIGH, HOLD and WAIT.
REQ-019 PWRUP: count T_PWRUP cycles, then go to INIT with init index 0.
REQ-020 INIT: load command ROM[index] (0x38, 0x38, 0x38, 0x0C, 0x01, 0x06) with rs=0 and enter SETUP; after WAIT, return to INIT with index+1; after index 5 completes, set init_done and go to IDLE.
REQ-021 IDLE: req_ready = 1 only when state is IDLE and init_done = 1; a transfer occurs when req_valid && req_ready, capturing req_rs and req_data into internal registers and entering SETUP next cycle.
REQ-022 SETUP: drive lcd_rs/lcd_data from the captured values with lcd_e = 0 for exactly T_SETUP cycles.
REQ-023 EHIGH: lcd_e = 1 for exactly T_EPW cycles; lcd_rs/lcd_data unchanged.
REQ-024 HOLD: lcd_e = 0 for exactly T_HOLD cycles; lcd_rs/lcd_data unchanged.
REQ-025 WAIT: T_CLR cycles if rs = 0 and data is 0x01, 0x02 or 0x03, otherwise T_CMD; then go to IDLE (or INIT during init).
REQ-026 Use one down-counter sized $clog2(max parameter)+1; load value-1 on state entry; leave the state when the counter is 0.
REQ-027 A request with rs = 0 and data = 0x00 SHALL still be written (no filtering).
REQ-028 req_valid while req_ready = 0 SHALL be ignored; the requester holds it (valid/ready rule); req_data changes while unaccepted have no effect.
REQ-029 Minimum accept-to-accept spacing SHALL be 1 + T_SETUP + T_EPW + T_HOLD + wait cycles.
REQ-030 lcd_rw SHALL be constant 0 in every state.

Reset
REQ-031 On a clk_clk edge with reset_reset_n = 0, SHALL enter PWRUP with lcd_e = 0, lcd_rs = 0, lcd_data = 0x00, req_ready = 0, init_done = 0, counter loaded with T_PWRUP-1 and init index 0.
REQ-032 Reset asserted mid-strobe SHALL drop lcd_e on that edge and rerun the full init sequence; no partial transfer resumes.

Structure
REQ-033 A shared package lcd_pkg SHALL hold the state enum, the init ROM constants, and the command codes CLR = 0x01 and HOME = 0x02.
REQ-034 One sub-module, lcd_timer (loadable down-counter with zero flag), SHALL be used; everything else stays in lcd_hd44780_ctrl.

Verification (bench parameters: T_PWRUP=20, T_SETUP=2, T_EPW=3, T_HOLD=2, T_CMD=10, T_CLR=30)
REQ-035 Reset, then release -> req_ready = 0 for 20 cycles, then six E pulses with data 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 and rs = 0; init_done rises after the last WAIT.
REQ-036 After init, send rs=1, data=0x41 -> lcd_data = 0x41 and lcd_rs = 1, E high exactly 3 cycles, 2 cycles after data setup; req_ready returns 18 cycles after accept (1+2+3+2+10).
REQ-037 Send rs=0, data=0x01 -> post-pulse wait is 30 cycles; send rs=1, data=0x01 -> wait is 10 cycles.
REQ-038 Hold req_valid high with 3 back-to-back bytes -> exactly 3 E pulses, each with the correct byte, never an overlapping strobe.
REQ-039 Assert reset_reset_n = 0 during EHIGH -> lcd_e = 0 the next cycle, init_done = 0, and the full init sequence repeats.
REQ-040 Assertion checks: lcd_rw always 0; lcd_data/lcd_rs stable whenever lcd_e = 1 or in HOLD.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-only controller.
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_INIT,
      ST_IDLE,
      ST_SETUP,
      ST_EHIGH,
      ST_HOLD,
      ST_WAIT
   } lcd_state_t;

   // Commands that need the long post-write delay on the panel.
   localparam logic [7:0] CMD_CLR  = 8'h01;
   localparam logic [7:0] CMD_HOME = 8'h02;

   // Power-up sequence: 8-bit bus/2 lines (x3), display on, clear, entry mode.
   localparam int         INIT_LEN = 6;
   localparam int         IDX_W    = 3;
   localparam logic [8*INIT_LEN-1:0] INIT_ROM =
      {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

   function automatic logic [7:0] init_rom_byte(input logic [IDX_W-1:0] idx);
      init_rom_byte = 8'h00;
      for (int i = 0; i < INIT_LEN; i++) begin
         if (idx == IDX_W'(i)) init_rom_byte = INIT_ROM[8*i +: 8];
      end
   endfunction

   // Clear and home are slow; the panel ignores bit 0 of home, so 0x03 is home too.
   function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
      is_slow_cmd = !rs && (data == CMD_CLR || data == CMD_HOME || data == 8'h03);
   endfunction

   function automatic int imax(input int a, input int b);
      imax = (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter that parks at zero and flags it.
module lcd_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_reg;

   // Load has priority; the owner drives load during reset so no reset is needed here.
   always_ff @(posedge clk) begin
      if (load) begin
         cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - W'(1);
      end
   end

   assign zero = (cnt_reg == '0);

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 8-bit write-only controller: power-up init, then valid/ready byte writes.
module lcd_hd44780_ctrl
   import lcd_pkg::*;
#(
   parameter int T_PWRUP = 750000,
   parameter int T_SETUP = 4,
   parameter int T_EPW   = 12,
   parameter int T_HOLD  = 4,
   parameter int T_CMD   = 2000,
   parameter int T_CLR   = 82000
) (
   input  logic       clk_clk,
   input  logic       reset_reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       init_done,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e,
   output logic [7:0] lcd_data
);

   localparam int T_MAX = imax(imax(imax(T_PWRUP, T_SETUP), imax(T_EPW, T_HOLD)),
                               imax(T_CMD, T_CLR));
   localparam int CNT_W = $clog2(T_MAX) + 1;

   lcd_state_t       state_reg, state_next;
   logic [IDX_W-1:0] idx_reg, idx_next;
   logic             init_done_reg, init_done_next;
   logic             rs_reg, rs_next;
   logic [7:0]       data_reg, data_next;

   logic             cnt_load;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_zero;

   lcd_timer #(.W(CNT_W)) u_timer (
      .clk      (clk_clk),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .zero     (cnt_zero)
   );

   // State and captured-byte registers; reset restarts the whole power-up sequence.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_reg     <= ST_PWRUP;
         idx_reg       <= '0;
         init_done_reg <= 1'b0;
         rs_reg        <= 1'b0;
         data_reg      <= 8'h00;
      end else begin
         state_reg     <= state_next;
         idx_reg       <= idx_next;
         init_done_reg <= init_done_next;
         rs_reg        <= rs_next;
         data_reg      <= data_next;
      end
   end

   // Next-state logic: timed states leave when the shared counter reaches zero.
   always_comb begin
      state_next     = state_reg;
      idx_next       = idx_reg;
      init_done_next = init_done_reg;
      rs_next        = rs_reg;
      data_next      = data_reg;
      case (state_reg)
         ST_PWRUP: begin
            if (cnt_zero) begin
               state_next = ST_INIT;
               idx_next   = '0;
            end
         end
         ST_INIT: begin
            rs_next    = 1'b0;
            data_next  = init_rom_byte(idx_reg);
            state_next = ST_SETUP;
         end
         ST_IDLE: begin
            if (req_valid && init_done_reg) begin
               rs_next    = req_rs;
               data_next  = req_data;
               state_next = ST_SETUP;
            end
         end
         ST_SETUP: if (cnt_zero) state_next = ST_EHIGH;
         ST_EHIGH: if (cnt_zero) state_next = ST_HOLD;
         ST_HOLD:  if (cnt_zero) state_next = ST_WAIT;
         ST_WAIT: begin
            if (cnt_zero) begin
               if (init_done_reg) begin
                  state_next = ST_IDLE;
               end else if (idx_reg == IDX_W'(INIT_LEN - 1)) begin
                  state_next     = ST_IDLE;
                  init_done_next = 1'b1;
               end else begin
                  state_next = ST_INIT;
                  idx_next   = idx_reg + IDX_W'(1);
               end
            end
         end
         default: state_next = ST_PWRUP;
      endcase
   end

   // Outputs and counter reload; the counter gets duration-1 on every state entry.
   always_comb begin
      req_ready = (state_reg == ST_IDLE) && init_done_reg;
      init_done = init_done_reg;
      lcd_e     = (state_reg == ST_EHIGH);
      lcd_rs    = rs_reg;
      lcd_data  = data_reg;
      lcd_rw    = 1'b0;

      cnt_load     = !reset_reset_n || (state_next != state_reg);
      cnt_load_val = '0;
      if (!reset_reset_n) begin
         cnt_load_val = CNT_W'(T_PWRUP - 1);
      end else begin
         case (state_next)
            ST_PWRUP: cnt_load_val = CNT_W'(T_PWRUP - 1);
            ST_SETUP: cnt_load_val = CNT_W'(T_SETUP - 1);
            ST_EHIGH: cnt_load_val = CNT_W'(T_EPW - 1);
            ST_HOLD:  cnt_load_val = CNT_W'(T_HOLD - 1);
            ST_WAIT:  cnt_load_val = is_slow_cmd(rs_reg, data_reg) ? CNT_W'(T_CLR - 1)
                                                                   : CNT_W'(T_CMD - 1);
            default:  cnt_load_val = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Directed bench for lcd_hd44780_ctrl with shortened timing parameters.
module tb_lcd_hd44780_ctrl;

   localparam int T_PWRUP = 20;
   localparam int T_SETUP = 2;
   localparam int T_EPW   = 3;
   localparam int T_HOLD  = 2;
   localparam int T_CMD   = 10;
   localparam int T_CLR   = 30;

   logic       clk_clk = 1'b0;
   logic       reset_reset_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_rs;
   logic [7:0] req_data;
   logic       init_done;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;
   logic [7:0] lcd_data;

   int tests_run    = 0;
   int tests_failed = 0;

   typedef struct {
      logic [7:0] d;
      logic       rs;
      int         len;
   } pulse_t;

   pulse_t     pq[$];
   pulse_t     cur;
   logic       prev_e    = 1'b0;
   int         hold_left = 0;
   logic [7:0] exp_rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

   always #5 clk_clk = ~clk_clk;

   lcd_hd44780_ctrl #(
      .T_PWRUP (T_PWRUP),
      .T_SETUP (T_SETUP),
      .T_EPW   (T_EPW),
      .T_HOLD  (T_HOLD),
      .T_CMD   (T_CMD),
      .T_CLR   (T_CLR)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_rs        (req_rs),
      .req_data      (req_data),
      .init_done     (init_done),
      .lcd_rs        (lcd_rs),
      .lcd_rw        (lcd_rw),
      .lcd_e         (lcd_e),
      .lcd_data      (lcd_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse recorder plus bus-stability and rw checks, sampled on the falling edge.
   always @(negedge clk_clk) begin
      chk("lcd_rw_low", 32'(lcd_rw), 32'd0);
      if (lcd_e === 1'b1) begin
         if (!prev_e) begin
            cur.d   = lcd_data;
            cur.rs  = lcd_rs;
            cur.len = 1;
         end else begin
            cur.len++;
            chk("ehigh_data_stable", 32'(lcd_data), 32'(cur.d));
            chk("ehigh_rs_stable", 32'(lcd_rs), 32'(cur.rs));
         end
      end else if (prev_e) begin
         pq.push_back(cur);
         hold_left = T_HOLD - 1;
         if (reset_reset_n === 1'b1) begin
            chk("hold_data_stable", 32'(lcd_data), 32'(cur.d));
            chk("hold_rs_stable", 32'(lcd_rs), 32'(cur.rs));
         end
      end else if (hold_left > 0) begin
         hold_left--;
         if (reset_reset_n === 1'b1) begin
            chk("hold_data_stable", 32'(lcd_data), 32'(cur.d));
            chk("hold_rs_stable", 32'(lcd_rs), 32'(cur.rs));
         end
      end
      prev_e = (lcd_e === 1'b1);
   end

   // Release reset and follow the power-up sequence to init_done.
   task automatic wait_init();
      int n;
      bit done;
      pq.delete();
      reset_reset_n = 1'b1;
      n    = 0;
      done = 1'b0;
      while (!done && n < 400) begin
         @(negedge clk_clk);
         n++;
         if (n <= T_PWRUP) begin
            chk("pwrup_ready", 32'(req_ready), 32'd0);
            chk("pwrup_e", 32'(lcd_e), 32'd0);
         end
         if (init_done === 1'b1) done = 1'b1;
         else chk("init_ready_low", 32'(req_ready), 32'd0);
      end
      // 20 power-up + 6 x (1 init + 2 + 3 + 2) + 5 x 10 + 30 waits = 148
      chk("init_done_cycle", 32'(n), 32'd148);
      chk("init_ready", 32'(req_ready), 32'd1);
      chk("init_pulses", 32'(pq.size()), 32'd6);
      for (int i = 0; i < 6 && i < pq.size(); i++) begin
         chk("init_pulse_data", 32'(pq[i].d), 32'(exp_rom[i]));
         chk("init_pulse_rs", 32'(pq[i].rs), 32'd0);
         chk("init_pulse_len", 32'(pq[i].len), 32'd3);
      end
      $display("[TB] init sequence: init_done after %0d cycles, %0d pulses", n, pq.size());
   endtask

   // One write: 2 setup, 3 E-high, 2 hold, then w wait cycles; ready returns at 8+w.
   task automatic xfer(input logic rs, input logic [7:0] d, input int w);
      int total;
      int base;
      total = 8 + w;
      base  = pq.size();
      chk("xfer_ready_before", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_rs    = rs;
      req_data  = d;
      for (int k = 1; k <= total; k++) begin
         @(negedge clk_clk);
         if (k == 1) begin
            req_valid = 1'b0;
            req_rs    = ~rs;
            req_data  = ~d;
         end
         chk("xfer_e", 32'(lcd_e), 32'(k >= 3 && k <= 5));
         chk("xfer_ready", 32'(req_ready), 32'(k == total));
         if (k <= 7) begin
            chk("xfer_rs", 32'(lcd_rs), 32'(rs));
            chk("xfer_data", 32'(lcd_data), 32'(d));
         end
      end
      chk("xfer_pulse_count", 32'(pq.size()), 32'(base + 1));
      if (pq.size() > base) begin
         chk("xfer_pulse_data", 32'(pq[base].d), 32'(d));
         chk("xfer_pulse_rs", 32'(pq[base].rs), 32'(rs));
         chk("xfer_pulse_len", 32'(pq[base].len), 32'd3);
      end
      $display("[TB] xfer rs=%0d data=%02h wait=%0d ready_after=%0d", rs, d, w, total);
   endtask

   initial begin
      logic [7:0] bb [3];
      int         acc_cyc [3];
      int         idx;
      int         cyc;
      int         base;
      bit         prev_acc;

      req_valid     = 1'b0;
      req_rs        = 1'b0;
      req_data      = 8'h00;
      reset_reset_n = 1'b0;
      repeat (3) @(negedge clk_clk);
      chk("rst_e", 32'(lcd_e), 32'd0);
      chk("rst_rs", 32'(lcd_rs), 32'd0);
      chk("rst_data", 32'(lcd_data), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_init_done", 32'(init_done), 32'd0);
      $display("[TB] reset state checked");

      wait_init();

      xfer(1'b1, 8'h41, T_CMD);
      xfer(1'b0, 8'h01, T_CLR);
      xfer(1'b1, 8'h01, T_CMD);
      xfer(1'b0, 8'h00, T_CMD);
      xfer(1'b0, 8'h02, T_CLR);
      xfer(1'b0, 8'h03, T_CLR);
      xfer(1'b0, 8'h04, T_CMD);

      // Back-to-back: valid stays high, next byte presented after each accept.
      bb       = '{8'h61, 8'h62, 8'h63};
      acc_cyc  = '{-1, -1, -1};
      base     = pq.size();
      idx      = 0;
      cyc      = 0;
      req_valid = 1'b1;
      req_rs    = 1'b1;
      req_data  = bb[0];
      prev_acc  = (req_ready === 1'b1);
      if (prev_acc) acc_cyc[0] = 0;
      while (idx < 3 && cyc < 200) begin
         @(negedge clk_clk);
         cyc++;
         if (prev_acc) begin
            idx++;
            if (idx < 3) req_data = bb[idx];
            else req_valid = 1'b0;
         end
         prev_acc = req_valid && (req_ready === 1'b1);
         if (prev_acc) acc_cyc[idx] = cyc;
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 32'(idx), 32'd3);
      chk("b2b_spacing_1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd18);
      chk("b2b_spacing_2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd18);
      repeat (17) @(negedge clk_clk);
      chk("b2b_ready_end", 32'(req_ready), 32'd1);
      chk("b2b_pulse_count", 32'(pq.size()), 32'(base + 3));
      for (int i = 0; i < 3 && base + i < pq.size(); i++) begin
         chk("b2b_pulse_data", 32'(pq[base + i].d), 32'(bb[i]));
         chk("b2b_pulse_len", 32'(pq[base + i].len), 32'd3);
      end
      $display("[TB] back-to-back: %0d bytes accepted at cycles %0d %0d %0d",
               idx, acc_cyc[0], acc_cyc[1], acc_cyc[2]);

      // Reset in the middle of the E strobe.
      chk("mid_ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_rs    = 1'b1;
      req_data  = 8'h5A;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk_clk);
         if (k == 1) req_valid = 1'b0;
      end
      chk("mid_e_high", 32'(lcd_e), 32'd1);
      reset_reset_n = 1'b0;
      @(negedge clk_clk);
      chk("mid_rst_e", 32'(lcd_e), 32'd0);
      chk("mid_rst_init_done", 32'(init_done), 32'd0);
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_rs", 32'(lcd_rs), 32'd0);
      chk("mid_rst_data", 32'(lcd_data), 32'd0);
      $display("[TB] reset during strobe: lcd_e=%0d init_done=%0d", lcd_e, init_done);
      repeat (2) @(negedge clk_clk);

      wait_init();
      xfer(1'b1, 8'h42, T_CMD);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
